logistic_iter: RTL
==================

Name: logistic_iter

Overview:
- Downstream consumer of the sample/mu selection stage.
- Takes the selected mu (Q2.16), maxrepeat (9-bit) and slow calc clock, and iterates the logistic map x(n+1) = mu*x(n)*(1-x(n)).
- Runs one iteration per rising edge of the slow calc clock and hands each point to the plot/display stage through a valid/ready handshake.
- Stops after maxrepeat points.

Parameters:
- XW, 16: x width, unsigned Q0.16.
- MUW, 18: mu width, unsigned Q2.16.
- CW, 9: iteration counter width; must match the maxrepeat width.
- SYNC_STAGES, 2: synchronizer depth for calc_clock.

Ports:
- CLK  input  1  system clock; all state on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- calc_clock  input  1  slow step clock from the selection stage; treated as data, synchronized, rising edge detected.
- start  input  1  one-cycle pulse; latches mu, maxrepeat and x0, then begins a run.
- mu  input  18  Q2.16 growth rate.
- maxrepeat  input  9  number of points to produce.
- x0  input  16  Q0.16 initial value.
- out_valid  output  1  point available.
- out_ready  input  1  consumer accepts the point.
- out_x  output  16  Q0.16 iterate x(n).
- out_idx  output  9  iteration index n, 1-based.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (RST=0, async): state=IDLE, all registers 0, synchronizer flops 0; out_valid=0, out_x=0, out_idx=0, busy=0, done=0.
- Step pulse: calc_clock passes through SYNC_STAGES flops plus an edge register. step is high for one CLK cycle per calc_clock rising edge.
- States: IDLE, WAIT, MUL1, MUL2, OUT.
- IDLE:
  - On start: latch mu_r, max_r and x_r=x0, clear cnt.
  - If maxrepeat=0: pulse done next cycle and stay in IDLE, producing no output.
  - Otherwise go to WAIT; busy=1 in every state except IDLE.
- WAIT: on step, go to MUL1.
- MUL1: om = 2^16 - x_r, 17-bit Q1.16 (x_r=0 gives 0x10000). p = (x_r*om)[31:16], Q0.16, max 0x4000.
- MUL2:
  - q = mu_r*p, 34-bit Q2.32.
  - If q[33:32]!=0, x_r=0xFFFF (saturate); else x_r=q[31:16] (truncate, no rounding).
  - cnt=cnt+1.
- OUT:
  - out_valid=1, out_x=x_r, out_idx=cnt.
  - Values hold stable until out_ready=1 is sampled; the transfer completes on that edge.
  - After transfer: if cnt==max_r, pulse done and go to IDLE; else go to WAIT.
- Latency: out_valid rises on the 3rd CLK edge after the edge where step=1.
- Dropped steps: a step arriving in any state other than WAIT is dropped (no queue). Back-pressure slows the map; it never skips iterations.
- start ignored while busy=1.
- mu/maxrepeat/x0 changes mid-run have no effect; only the latched copies are used.
- RST assertion mid-run aborts immediately to the reset state; no done pulse.
- cnt is 9-bit; maxrepeat max 511, so no wrap.
- out_valid is never combinationally dependent on out_ready.

Test Plan:
- Fixed point: mu=0x20000 (2.0), x0=0x8000, maxrepeat=3, out_ready=1, three calc_clock edges -> three transfers with out_x=0x8000 and out_idx=1,2,3; done pulses once after the 3rd; busy=0.
- Near-max mu: mu=0x3FFFF, x0=0x8000, maxrepeat=1 -> out_x=0xFFFF, no saturation flag path taken. Forced case mu=0x3FFFF with p=0x4000 confirms q=0xFFFFC000.
- Zero boundaries: x0=0 with mu=0x2DBDF -> out_x=0 every step (om=0x10000 handled). Separately, maxrepeat=0 -> done one cycle after start, out_valid never asserts.
- Back-pressure: out_ready=0 for 10 calc_clock edges after the first point -> out_x/out_idx stable, those steps dropped. Then out_ready=1 -> next point has out_idx=2.
- Latency/sync: a single calc_clock rising edge -> step pulse exactly SYNC_STAGES+1 CLK edges later; out_valid exactly 3 edges after step. A calc_clock high level for 50 cycles produces only one step.
- Reset mid-run: assert RST low while in MUL2 at cnt=4 -> outputs immediately 0, state IDLE, no done. A new start then runs from out_idx=1.

Source files
------------

// File: rtl/logistic_iter.sv
`default_nettype none
// ============================================================================
// Module   : logistic_iter
// Brief    : Fixed-point logistic map iterator x(n+1) = mu*x(n)*(1-x(n)).
//            One iteration per rising edge of a slow step clock. Each point
//            is handed downstream over a valid/ready handshake. A run stops
//            after maxrepeat points.
// Revision : 1.0 - initial release
// ============================================================================
module logistic_iter #(
  parameter int XW          = 16,  // x width, unsigned Q0.16
  parameter int MUW         = 18,  // mu width, unsigned Q2.16
  parameter int CW          = 9,   // iteration counter width (matches maxrepeat)
  parameter int SYNC_STAGES = 2    // synchronizer depth for calc_clock
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           calc_clock,
  input  logic           start,
  input  logic [MUW-1:0] mu,
  input  logic [CW-1:0]  maxrepeat,
  input  logic [XW-1:0]  x0,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [XW-1:0]  out_x,
  output logic [CW-1:0]  out_idx,
  output logic           busy,
  output logic           done
);

  // 1.0 in Q1.XW, used to form (1 - x)
  localparam logic [XW:0] X_ONE = {1'b1, {XW{1'b0}}};
  localparam int PW = 2 * XW + 1;   // width of x*(1-x) product
  localparam int QW = MUW + XW;     // width of mu*p product

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state;

  // Step clock synchronizer and edge detector
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   step;

  // Latched run parameters and datapath state
  logic [MUW-1:0] mu_r;
  logic [CW-1:0]  max_r;
  logic [CW-1:0]  cnt;
  logic [XW-1:0]  x_r;
  logic [XW-1:0]  p_r;

  // Datapath arithmetic
  logic [XW:0]    om;
  logic [PW-1:0]  prod;
  logic [QW-1:0]  q;
  logic           sat;
  logic [XW-1:0]  x_next;
  logic           unused_bits;

  // calc_clock is asynchronous data: shift it through the synchronizer chain
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= calc_clock;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Registered rising-edge detect: one CLK-wide step per calc_clock rise
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_prev <= 1'b0;
      step      <= 1'b0;
    end else begin
      sync_prev <= sync_q[SYNC_STAGES-1];
      step      <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  // Map arithmetic: p = x*(1-x) in Q0.16, q = mu*p in Q2.32, saturate on overflow
  always_comb begin
    om     = X_ONE - {1'b0, x_r};
    prod   = {{(XW + 1){1'b0}}, x_r} * {{XW{1'b0}}, om};
    q      = {{XW{1'b0}}, mu_r} * {{MUW{1'b0}}, p_r};
    sat    = |q[QW-1:2*XW];
    x_next = sat ? {XW{1'b1}} : q[2*XW-1:XW];
    // Truncated fraction bits and the unreachable product MSB are dropped
    unused_bits = ^{prod[PW-1], prod[XW-1:0], q[XW-1:0]};
  end

  // Run control: latch on start, iterate per step, present each point, count
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      mu_r      <= '0;
      max_r     <= '0;
      cnt       <= '0;
      x_r       <= '0;
      p_r       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mu_r  <= mu;
            max_r <= maxrepeat;
            x_r   <= x0;
            cnt   <= '0;
            if (maxrepeat == '0) begin
              // Empty run: acknowledge immediately, produce nothing
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // Steps arriving in any other state are simply dropped
          if (step) begin
            state <= S_MUL1;
          end
        end

        S_MUL1: begin
          p_r   <= prod[2*XW-1:XW];
          state <= S_MUL2;
        end

        S_MUL2: begin
          x_r       <= x_next;
          cnt       <= cnt + 1'b1;
          out_valid <= 1'b1;
          out_x     <= x_next;
          out_idx   <= cnt + 1'b1;
          state     <= S_OUT;
        end

        S_OUT: begin
          // Hold the point until the consumer takes it; never skip iterations
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt == max_r) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
